chess_turn_scheduler: RTL
=========================

Name: chess_turn_scheduler

Overview:
Turn and timing controller for the timed chess game. It decides which player owns the move and gates access to the chess layout move/lock datapath. It runs per-player countdown clocks with a Fischer increment and declares timeout or game over. It sits between the board-control inputs and the layout matrix: the layout reports each committed move, and the scheduler grants the next turn.

Parameters:
TICKS_PER_SECOND, 50000000, clock cycles per one-second tick; must be >= 2
START_SECONDS, 300, initial time per player in seconds
INCREMENT_SECONDS, 2, seconds credited to the mover on each committed move
TIME_WIDTH, 10, bit width of each player's time counter; must hold START_SECONDS

Ports:
clock  input  1  system clock
resetApp  input  1  synchronous active-high reset
StartGame  input  1  single-cycle pulse: start the game from IDLE, or reload from GAME_OVER
Pause  input  1  level; high suspends the game while in RUN or PAUSED
MoveCommit  input  1  single-cycle pulse from the layout datapath when a legal move is written
Resign  input  1  single-cycle pulse; the player to move resigns
Player  output  1  side to move: 1 = White, 0 = Black
MoveEnable  output  1  high only in RUN; the layout may accept lock/move only while high
WhiteTime  output  TIME_WIDTH  White remaining seconds
BlackTime  output  TIME_WIDTH  Black remaining seconds
GameState  output  2  0 IDLE, 1 RUN, 2 PAUSED, 3 GAME_OVER
Winner  output  1  valid in GAME_OVER: 1 = White, 0 = Black
Timeout  output  1  high in GAME_OVER when the game ended on time
MoveCount  output  8  committed moves (plies), saturates at 255

Behaviour:
- All outputs are registered and updated on posedge clock. resetApp has priority over every other input.
- Reset values:
  - GameState = IDLE, Player = 1, WhiteTime = BlackTime = START_SECONDS.
  - Winner = 0, Timeout = 0, MoveCount = 0, MoveEnable = 0.
  - Internal prescaler = 0.
- Prescaler:
  - Counts 0..TICKS_PER_SECOND-1 in RUN only. Held in PAUSED. Cleared in IDLE and GAME_OVER and on every turn switch.
  - A tick occurs in the cycle the prescaler equals TICKS_PER_SECOND-1; the prescaler then wraps to 0.
- IDLE:
  - StartGame -> RUN next cycle.
  - Pause, MoveCommit and Resign are ignored.
- RUN, evaluated in this priority order:
  1. Resign: -> GAME_OVER, Winner = ~Player, Timeout = 0.
  2. MoveCommit:
     - Mover time += INCREMENT_SECONDS, saturating at 2^TIME_WIDTH-1.
     - Player toggles; MoveCount increments (saturating); prescaler clears.
     - A tick in the same cycle is discarded, so no decrement happens.
  3. Tick: active player's time decrements by 1. If the result is 0, -> GAME_OVER next cycle with time shown as 0, Winner = ~Player, Timeout = 1.
  4. Pause high (and none of 1–3): -> PAUSED.
- PAUSED:
  - Pause low -> RUN. Times and prescaler are frozen.
  - MoveCommit is ignored; MoveEnable = 0.
  - Resign -> GAME_OVER, Winner = ~Player.
- GAME_OVER:
  - All inputs except StartGame are ignored; outputs hold.
  - StartGame -> IDLE with times reloaded, Player = 1, MoveCount = 0, Timeout = 0, Winner = 0.
- MoveEnable = (next GameState == RUN). It deasserts in the same cycle GameState leaves RUN.
- StartGame outside IDLE and GAME_OVER is ignored.
- Time never underflows: a decrement is applied only when the value is > 0.
- A time of 0 is reachable only through timeout.
- Reset mid-game: next cycle is IDLE with all reset values, regardless of any other inputs.

Test Plan:
Use TICKS_PER_SECOND=4, START_SECONDS=3, INCREMENT_SECONDS=1 throughout.
- Reset then StartGame pulse -> GameState=1, Player=1, MoveEnable=1, WhiteTime=3, BlackTime=3; after 4 cycles WhiteTime=2 and BlackTime=3.
- In RUN at WhiteTime=2, MoveCommit -> WhiteTime=3, Player=0, MoveCount=1, prescaler cleared; BlackTime=2 after exactly 4 further cycles.
- No moves from start -> WhiteTime reaches 0 after 12 cycles; GameState=3, Timeout=1, Winner=0, MoveEnable=0; further MoveCommit changes nothing.
- MoveCommit in the same cycle as a tick at WhiteTime=1 -> no timeout; WhiteTime=2, Player=0, GameState=1.
- Pause high for 10 cycles mid-turn -> GameState=2, times frozen, MoveCommit ignored; after release, the remaining prescaler count resumes where it stopped.
- Resign by Black (Player=0) -> GameState=3, Winner=1, Timeout=0; StartGame -> IDLE with times=3 and MoveCount=0; resetApp asserted mid-RUN -> IDLE next cycle.

Source files
------------

// File: rtl/chess_turn_scheduler.sv
// chess_turn_scheduler
// Turn and clock controller for a timed chess game. It decides which side owns
// the move and opens the layout move/lock datapath (MoveEnable) only while the
// game is running. Each side has a countdown clock in seconds. A committed move
// credits a Fischer increment to the mover and hands the turn over. A clock
// that reaches zero, or a resignation, ends the game.
//
// Ports:
//   clock       system clock
//   resetApp    synchronous active-high reset; overrides every other input
//   StartGame   pulse: IDLE -> RUN, or GAME_OVER -> IDLE with the clocks reloaded
//   Pause       level: suspends the game while it is in RUN or PAUSED
//   MoveCommit  pulse from the layout datapath when a legal move is written
//   Resign      pulse: the side to move resigns
//   Player      side to move (1 = White, 0 = Black)
//   MoveEnable  high only while the registered state is RUN
//   WhiteTime   White remaining seconds
//   BlackTime   Black remaining seconds
//   GameState   0 IDLE, 1 RUN, 2 PAUSED, 3 GAME_OVER
//   Winner      winning side, valid in GAME_OVER
//   Timeout     high in GAME_OVER when the game ended on time
//   MoveCount   committed plies, saturating at 255
module chess_turn_scheduler #(
  parameter int TICKS_PER_SECOND  = 50000000,
  parameter int START_SECONDS     = 300,
  parameter int INCREMENT_SECONDS = 2,
  parameter int TIME_WIDTH        = 10
) (
  input  logic                  clock,
  input  logic                  resetApp,
  input  logic                  StartGame,
  input  logic                  Pause,
  input  logic                  MoveCommit,
  input  logic                  Resign,
  output logic                  Player,
  output logic                  MoveEnable,
  output logic [TIME_WIDTH-1:0] WhiteTime,
  output logic [TIME_WIDTH-1:0] BlackTime,
  output logic [1:0]            GameState,
  output logic                  Winner,
  output logic                  Timeout,
  output logic [7:0]            MoveCount
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] PAUSED    = 2'd2;
  localparam logic [1:0] GAME_OVER = 2'd3;

  localparam int PW = $clog2(TICKS_PER_SECOND);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SECOND - 1);
  localparam int unsigned TIME_MAX = (1 << TIME_WIDTH) - 1;
  localparam logic [TIME_WIDTH-1:0] TIME_START = TIME_WIDTH'(START_SECONDS);

  // Increment with saturation at the top of the time counter range.
  function automatic logic [TIME_WIDTH-1:0] sat_add(input logic [TIME_WIDTH-1:0] t);
    logic [32:0] sum;
    sum = {{(33-TIME_WIDTH){1'b0}}, t} + 33'(INCREMENT_SECONDS);
    if (sum > 33'(TIME_MAX)) begin
      sat_add = TIME_WIDTH'(TIME_MAX);
    end else begin
      sat_add = sum[TIME_WIDTH-1:0];
    end
  endfunction

  logic [1:0]            state_r, state_s;
  logic                  player_r, player_s;
  logic [TIME_WIDTH-1:0] white_r, white_s;
  logic [TIME_WIDTH-1:0] black_r, black_s;
  logic                  winner_r, winner_s;
  logic                  timeout_r, timeout_s;
  logic [7:0]            count_r, count_s;
  logic [PW-1:0]         presc_r, presc_s;
  logic                  enable_r;
  logic                  tick_s;
  logic [TIME_WIDTH-1:0] cur_time_s, dec_time_s;

  // Next-state and datapath decisions for one clock.
  always_comb begin
    state_s   = state_r;
    player_s  = player_r;
    white_s   = white_r;
    black_s   = black_r;
    winner_s  = winner_r;
    timeout_s = timeout_r;
    count_s   = count_r;
    presc_s   = presc_r;
    tick_s    = (presc_r == PRESC_LAST);
    cur_time_s = player_r ? white_r : black_r;
    // The guard keeps the clock from wrapping below zero.
    if (cur_time_s != '0) begin
      dec_time_s = cur_time_s - TIME_WIDTH'(1);
    end else begin
      dec_time_s = cur_time_s;
    end

    case (state_r)
      IDLE: begin
        presc_s = '0;
        if (StartGame) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (Resign) begin
          state_s   = GAME_OVER;
          winner_s  = ~player_r;
          timeout_s = 1'b0;
          presc_s   = '0;
        end else if (MoveCommit) begin
          // A tick landing in the commit cycle is dropped on purpose.
          if (player_r) begin
            white_s = sat_add(white_r);
          end else begin
            black_s = sat_add(black_r);
          end
          player_s = ~player_r;
          count_s  = (count_r == 8'd255) ? count_r : count_r + 8'd1;
          presc_s  = '0;
        end else if (tick_s) begin
          presc_s = '0;
          if (player_r) begin
            white_s = dec_time_s;
          end else begin
            black_s = dec_time_s;
          end
          if (dec_time_s == '0) begin
            state_s   = GAME_OVER;
            winner_s  = ~player_r;
            timeout_s = 1'b1;
          end else begin
            state_s = RUN;
          end
        end else begin
          // The cycle that enters PAUSED still counts as a RUN cycle.
          presc_s = presc_r + PW'(1);
          if (Pause) begin
            state_s = PAUSED;
          end else begin
            state_s = RUN;
          end
        end
      end
      PAUSED: begin
        if (Resign) begin
          state_s   = GAME_OVER;
          winner_s  = ~player_r;
          timeout_s = 1'b0;
          presc_s   = '0;
        end else if (!Pause) begin
          state_s = RUN;
        end else begin
          state_s = PAUSED;
        end
      end
      GAME_OVER: begin
        presc_s = '0;
        if (StartGame) begin
          state_s   = IDLE;
          player_s  = 1'b1;
          white_s   = TIME_START;
          black_s   = TIME_START;
          winner_s  = 1'b0;
          timeout_s = 1'b0;
          count_s   = 8'd0;
        end else begin
          state_s = GAME_OVER;
        end
      end
      default: begin
        state_s = IDLE;
        presc_s = '0;
      end
    endcase
  end

  // State and output registers; resetApp wins over everything.
  always_ff @(posedge clock) begin
    if (resetApp) begin
      state_r   <= IDLE;
      player_r  <= 1'b1;
      white_r   <= TIME_START;
      black_r   <= TIME_START;
      winner_r  <= 1'b0;
      timeout_r <= 1'b0;
      count_r   <= 8'd0;
      presc_r   <= '0;
      enable_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      player_r  <= player_s;
      white_r   <= white_s;
      black_r   <= black_s;
      winner_r  <= winner_s;
      timeout_r <= timeout_s;
      count_r   <= count_s;
      presc_r   <= presc_s;
      enable_r  <= (state_s == RUN);
    end
  end

  assign GameState  = state_r;
  assign Player     = player_r;
  assign WhiteTime  = white_r;
  assign BlackTime  = black_r;
  assign Winner     = winner_r;
  assign Timeout    = timeout_r;
  assign MoveCount  = count_r;
  assign MoveEnable = enable_r;

endmodule
